ram_slot_arbiter: RTL
=====================

Name: ram_slot_arbiter

Overview:
- Schedules the shared DRAM bus, one requester per memory slot, on the slot grid produced by the MCU clock generator.
- Each slot is 250 ns, i.e. 8 clk32 cycles. Slots alternate between phase 0 (video/refresh) and phase 1 (DMA/CPU).
- Requesters use a req/ack handshake. Grants are one-hot and held for the whole slot.
- The block also owns the DRAM refresh request timer and the DMA-vs-CPU fairness limit.

Parameters:
- REF_INTERVAL, 32: number of phase-0 slots between refresh requests (32 × 500 ns = 16 µs).
- REF_URGENT, 4: pending-refresh count at or above which refresh pre-empts video.
- DMA_RUN_MAX, 3: maximum consecutive DMA grants before a requesting CPU must win.
- PEND_W, 3: width of the pending-refresh counter. The counter saturates at 2^PEND_W−1.

Ports:
- clk32  in  1  system clock, 32 MHz. All logic is clocked on its rising edge.
- reset  in  1  synchronous reset, active high.
- slot_en  in  1  one-cycle strobe, one clk32 before each slot boundary. Derived from cycsel_en/addrsel. Period is 8 clocks.
- slot_phase  in  1  class of the upcoming slot, sampled with slot_en: 0 = video/refresh slot, 1 = DMA/CPU slot.
- req_vid  in  1  shifter load request. Level; held until ack.
- req_dma  in  1  DMA request. Level; held until ack.
- req_cpu  in  1  68000 bus request. Level; held until ack.
- gnt_vid  out  1  video owns the current slot.
- gnt_ref  out  1  refresh owns the current slot.
- gnt_dma  out  1  DMA owns the current slot.
- gnt_cpu  out  1  CPU owns the current slot.
- ack_vid  out  1  one-cycle pulse: video access complete.
- ack_dma  out  1  one-cycle pulse: DMA access complete.
- ack_cpu  out  1  one-cycle pulse: CPU access complete.
- slot_busy  out  1  OR of all gnt_*.
- ref_pend  out  PEND_W  number of pending refreshes.

Behaviour:
- Reset values:
  - All gnt_* and ack_* are 0; slot_busy is 0.
  - ref_pend is 0; the refresh slot counter is 0; the DMA run counter is 0.
  - The FSM is in IDLE.
  - Reset mid-slot: grants drop on the next clock and no ack is issued.
- FSM states:
  - IDLE: no owner.
  - OWNED: one gnt_* is high.
  - Transitions are evaluated only on slot_en. Between strobes, gnt_* and the state are frozen.
- Arbitration:
  - Computed combinationally on the slot_en cycle from req_* and slot_phase.
  - gnt_* is registered, so it rises on the clock after slot_en, i.e. at the slot start. Latency from slot_en to grant is 1 clock.
- Phase 0 priority:
  1. ref, if ref_pend ≥ REF_URGENT.
  2. vid.
  3. ref, if ref_pend ≠ 0.
  4. Otherwise IDLE.
- Phase 1 priority:
  - cpu wins if req_cpu and dma_run ≥ DMA_RUN_MAX.
  - Otherwise dma wins if req_dma.
  - Otherwise cpu wins if req_cpu.
  - Otherwise IDLE.
- DMA run counter (dma_run):
  - Increments, saturating, on each DMA grant.
  - Clears on any CPU grant, and on any phase-1 slot with no req_dma.
- Ack rules:
  - On a slot_en that occurs while OWNED, the current owner's ack_* pulses for that single cycle, i.e. the last clock of its slot.
  - The ack is issued only if the owner's req is still high. A requester that drops req mid-slot is aborted: its grant is held to slot end and no ack is given.
  - Refresh has no ack.
  - A requester acked on a slot_en can be regranted the next slot of the same class if req stays high.
- Refresh timer:
  - The slot counter increments on every slot_en with slot_phase=0 and wraps REF_INTERVAL−1 → 0.
  - On the wrap, ref_pend increments, saturating at 2^PEND_W−1.
  - A refresh grant decrements ref_pend on the grant clock.
  - Wrap and refresh grant on the same slot_en: ref_pend is unchanged.
- A slot_en with no requesters moves the FSM to IDLE and all gnt_* go to 0.
- Invariants:
  - gnt_* is never more than one-hot.
  - ack_* is only asserted on slot_en cycles.
  - slot_phase is ignored outside slot_en.

Test Plan:
- req_vid=1 held, phase alternating 0/1, ref_pend=0 → gnt_vid high for 8 clocks starting 1 clk after each phase-0 slot_en. ack_vid pulses on each following slot_en. gnt_vid is never high in phase 1.
- req_dma=1 and req_cpu=1 held over 8 phase-1 slots, DMA_RUN_MAX=3 → grant sequence is DMA, DMA, DMA, CPU, DMA, DMA, DMA, CPU. The acks match that sequence.
- No requests for 32 phase-0 slots → ref_pend reaches 1 at the 32nd slot_en. The next phase-0 slot gives gnt_ref, and ref_pend returns to 0.
- req_vid held continuously for 128 phase-0 slots → ref_pend climbs to 4. The next phase-0 slot grants ref over vid, ref_pend drops to 3, and vid resumes from the following phase-0 slot.
- req_cpu granted, then req_cpu dropped 3 clocks into the slot → gnt_cpu is held to slot end and ack_cpu is never pulsed. Then assert reset for 1 clock mid-slot with gnt_dma high → all outputs are 0 on the next clock and ref_pend=0.
- Refresh wrap and refresh grant on the same slot_en with ref_pend=2 → ref_pend stays 2. With ref_pend=7 and a wrap (PEND_W=3) → ref_pend stays 7.

Source files
------------

// File: rtl/ram_slot_arbiter.sv
// DRAM slot arbiter: hands each 250 ns memory slot to one requester
// (video/refresh on phase-0 slots, DMA/CPU on phase-1 slots), owns the
// refresh request timer and the DMA-vs-CPU fairness limit.
module ram_slot_arbiter #(
  parameter int REF_INTERVAL = 32,
  parameter int REF_URGENT   = 4,
  parameter int DMA_RUN_MAX  = 3,
  parameter int PEND_W       = 3
) (
  input  logic              clk32,
  input  logic              reset,
  input  logic              slot_en,
  input  logic              slot_phase,
  input  logic              req_vid,
  input  logic              req_dma,
  input  logic              req_cpu,
  output logic              gnt_vid,
  output logic              gnt_ref,
  output logic              gnt_dma,
  output logic              gnt_cpu,
  output logic              ack_vid,
  output logic              ack_dma,
  output logic              ack_cpu,
  output logic              slot_busy,
  output logic [PEND_W-1:0] ref_pend
);

  localparam int SLOT_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam int RUN_W  = (DMA_RUN_MAX > 0) ? $clog2(DMA_RUN_MAX + 1) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REF_INTERVAL - 1);
  localparam logic [PEND_W-1:0] PEND_SAT  = {PEND_W{1'b1}};
  localparam logic [RUN_W-1:0]  RUN_SAT   = RUN_W'(DMA_RUN_MAX);

  // Bit positions inside the one-hot grant vector.
  localparam int G_VID = 3;
  localparam int G_REF = 2;
  localparam int G_DMA = 1;
  localparam int G_CPU = 0;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t             state_q, state_d;
  logic [3:0]         gnt_q, gnt_d;
  logic [PEND_W-1:0]  pend_q, pend_d;
  logic [SLOT_W-1:0]  slot_cnt_q, slot_cnt_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               wrap;
  logic               pend_urgent;
  logic               ack_vid_c, ack_dma_c, ack_cpu_c;

  // State register: everything clears on reset, so a mid-slot reset drops grants.
  always_ff @(posedge clk32) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      pend_q     <= '0;
      slot_cnt_q <= '0;
      run_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      pend_q     <= pend_d;
      slot_cnt_q <= slot_cnt_d;
      run_q      <= run_d;
    end
  end

  // Next-slot arbitration, acks, refresh timer and DMA run tracking; all
  // state is frozen except on the slot_en strobe.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    pend_d      = pend_q;
    slot_cnt_d  = slot_cnt_q;
    run_d       = run_q;
    wrap        = 1'b0;
    ack_vid_c   = 1'b0;
    ack_dma_c   = 1'b0;
    ack_cpu_c   = 1'b0;
    pend_urgent = (int'({1'b0, pend_q}) >= REF_URGENT);

    if (slot_en) begin
      // Close the current slot: ack the owner only if it still wants the bus.
      if (state_q == OWNED && !reset) begin
        ack_vid_c = gnt_q[G_VID] & req_vid;
        ack_dma_c = gnt_q[G_DMA] & req_dma;
        ack_cpu_c = gnt_q[G_CPU] & req_cpu;
      end

      gnt_d = '0;
      if (!slot_phase) begin
        if (pend_urgent)        gnt_d[G_REF] = 1'b1;
        else if (req_vid)       gnt_d[G_VID] = 1'b1;
        else if (pend_q != '0)  gnt_d[G_REF] = 1'b1;
      end else begin
        if (req_cpu && run_q >= RUN_SAT) gnt_d[G_CPU] = 1'b1;
        else if (req_dma)                gnt_d[G_DMA] = 1'b1;
        else if (req_cpu)                gnt_d[G_CPU] = 1'b1;
      end
      state_d = (gnt_d != '0) ? OWNED : IDLE;

      // Fairness: count back-to-back DMA wins, forget them once the CPU
      // gets in or DMA stops asking.
      if (gnt_d[G_DMA]) begin
        if (run_q != RUN_SAT) run_d = run_q + 1'b1;
      end else if (gnt_d[G_CPU] || (slot_phase && !req_dma)) begin
        run_d = '0;
      end

      // Refresh timer ticks on phase-0 slots; a wrap and a refresh grant
      // in the same strobe cancel out.
      if (!slot_phase) begin
        wrap       = (slot_cnt_q == SLOT_LAST);
        slot_cnt_d = wrap ? '0 : slot_cnt_q + 1'b1;
      end
      if (wrap && !gnt_d[G_REF]) begin
        if (pend_q != PEND_SAT) pend_d = pend_q + 1'b1;
      end else if (!wrap && gnt_d[G_REF]) begin
        pend_d = pend_q - 1'b1;
      end
    end
  end

  assign gnt_vid   = gnt_q[G_VID];
  assign gnt_ref   = gnt_q[G_REF];
  assign gnt_dma   = gnt_q[G_DMA];
  assign gnt_cpu   = gnt_q[G_CPU];
  assign ack_vid   = ack_vid_c;
  assign ack_dma   = ack_dma_c;
  assign ack_cpu   = ack_cpu_c;
  assign slot_busy = |gnt_q;
  assign ref_pend  = pend_q;

endmodule
